// File: rtl/isa_pkg.sv
// Vector ISA encoding shared by fetch, decode and execute: opcodes, branch
// codes, instruction field positions and the decoded-instruction record.
package isa_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b101010;
  localparam logic [5:0] OP_VBNZ  = 6'b100010;
  localparam logic [5:0] OP_VBENZ = 6'b100011;
  localparam logic [5:0] OP_LD    = 6'b100000;
  localparam logic [5:0] OP_SD    = 6'b100001;
  localparam logic [5:0] OP_NOP   = 6'b111100;

  localparam logic [1:0] BR_NONE  = 2'b00;
  localparam logic [1:0] BR_VBNZ  = 2'b10;
  localparam logic [1:0] BR_VBENZ = 2'b11;

  // Field A [25:21] is rd (R/LD/SD) or ra (branches); B and C are R-type sources.
  localparam int OP_HI  = 31, OP_LO  = 26;
  localparam int FA_HI  = 25, FA_LO  = 21;
  localparam int FB_HI  = 20, FB_LO  = 16;
  localparam int FC_HI  = 15, FC_LO  = 11;
  localparam int WW_HI  = 10, WW_LO  = 6;
  localparam int FN_HI  = 5,  FN_LO  = 0;
  localparam int IMM_HI = 15, IMM_LO = 0;

  typedef struct packed {
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  rd;
    logic [4:0]  ww;
    logic [5:0]  func;
    logic [1:0]  br;
    logic [15:0] imm;
    logic        wr_en;
    logic        mem_en;
    logic        store_en;
    logic        load;
    logic        illegal;
  } dec_t;

  function automatic dec_t decode(input logic [31:0] instr);
    dec_t       d;
    logic [5:0] op;
    d  = '0;
    op = instr[OP_HI:OP_LO];
    case (op)
      OP_RTYPE: begin
        d.rd    = instr[FA_HI:FA_LO];
        d.ra    = instr[FB_HI:FB_LO];
        d.rb    = instr[FC_HI:FC_LO];
        d.ww    = instr[WW_HI:WW_LO];
        d.func  = instr[FN_HI:FN_LO];
        d.wr_en = 1'b1;
      end
      OP_VBNZ, OP_VBENZ: begin
        d.ra  = instr[FA_HI:FA_LO];
        d.br  = (op == OP_VBNZ) ? BR_VBNZ : BR_VBENZ;
        d.imm = instr[IMM_HI:IMM_LO];
      end
      OP_LD: begin
        d.rd     = instr[FA_HI:FA_LO];
        d.imm    = instr[IMM_HI:IMM_LO];
        d.wr_en  = 1'b1;
        d.mem_en = 1'b1;
        d.load   = 1'b1;
      end
      OP_SD: begin
        d.rd       = instr[FA_HI:FA_LO];
        d.imm      = instr[IMM_HI:IMM_LO];
        d.mem_en   = 1'b1;
        d.store_en = 1'b1;
      end
      OP_NOP: ;
      default: d.illegal = 1'b1;
    endcase
    return d;
  endfunction

  // Which register fields an opcode reads or rewrites: bit0 field A, bit1 B, bit2 C.
  function automatic logic [2:0] src_en(input logic [5:0] op);
    case (op)
      OP_RTYPE:                       return 3'b111;
      OP_VBNZ, OP_VBENZ, OP_LD, OP_SD: return 3'b001;
      default:                        return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_pipe_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface decode_stage_pipe_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_ra;
  logic [4:0]  out_rb;
  logic [4:0]  out_rd;
  logic [4:0]  out_ww;
  logic [5:0]  out_func;
  logic [1:0]  out_br;
  logic [15:0] out_imm;
  logic        out_wr_en;
  logic        out_mem_en;
  logic        out_store_en;
  logic        out_load;
  logic        out_illegal;

  modport master (
    output in_valid, in_instr, flush, out_ready,
    input  in_ready, out_valid, out_ra, out_rb, out_rd, out_ww, out_func,
           out_br, out_imm, out_wr_en, out_mem_en, out_store_en, out_load, out_illegal
  );

  modport slave (
    input  in_valid, in_instr, flush, out_ready,
    output in_ready, out_valid, out_ra, out_rb, out_rd, out_ww, out_func,
           out_br, out_imm, out_wr_en, out_mem_en, out_store_en, out_load, out_illegal
  );
endinterface

// File: rtl/load_scoreboard.sv
// Tracks destination registers of in-flight loads until their data is usable.
module load_scoreboard #(
  parameter int SB_DEPTH = 2,
  parameter int LOAD_LAT = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alloc,
  input  logic [4:0]      alloc_rd,
  input  logic [2:0][4:0] q_addr,
  input  logic [2:0]      q_en,
  output logic            hit,
  output logic            full
);
  localparam logic [2:0] LAT_C = 3'(LOAD_LAT);

  logic [SB_DEPTH-1:0]      live;
  logic [SB_DEPTH-1:0]      alloc_sel;
  logic [SB_DEPTH-1:0][4:0] rd_q;
  logic [SB_DEPTH-1:0][2:0] cnt_q;
  logic                     taken;

  assign full = &live;

  // Any enabled query address matching a live entry's rd.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      for (int q = 0; q < 3; q++)
        if (live[i] && q_en[q] && (rd_q[i] == q_addr[q])) hit = 1'b1;
  end

  // Lowest free entry receives a new allocation.
  always_comb begin
    alloc_sel = '0;
    taken     = 1'b0;
    for (int i = 0; i < SB_DEPTH; i++)
      if (!live[i] && !taken) begin
        alloc_sel[i] = alloc;
        taken        = 1'b1;
      end
  end

  // Count live entries down; an entry retires as its count reaches zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        if (live[i]) begin
          cnt_q[i] <= cnt_q[i] - 3'd1;
          if (cnt_q[i] == 3'd1) live[i] <= 1'b0;
        end else if (alloc_sel[i]) begin
          live[i]  <= 1'b1;
          rd_q[i]  <= alloc_rd;
          cnt_q[i] <= LAT_C;
        end
      end
    end
  end
endmodule

// File: rtl/decode_stage_pipe.sv
// Decode stage: combinational decode into a ready/valid ID/EX register with
// load-use interlock, flush and a saturating illegal-opcode counter.
module decode_stage_pipe
  import isa_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int SB_DEPTH = 2,
  parameter int CNT_W    = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  decode_stage_pipe_if.slave   bus,
  output logic [CNT_W-1:0]     illegal_cnt
);
  dec_t            dec_c;
  dec_t            dec_p1;
  logic            vld_p1;
  logic [2:0]      q_en;
  logic [2:0][4:0] q_addr;
  logic            hit;
  logic            full;
  logic            sb_block;
  logic            ready_c;
  logic            accept;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign dec_c  = decode(bus.in_instr);
  assign q_en   = src_en(bus.in_instr[OP_HI:OP_LO]);
  assign q_addr = {bus.in_instr[FC_HI:FC_LO], bus.in_instr[FB_HI:FB_LO],
                   bus.in_instr[FA_HI:FA_LO]};

  assign sb_block     = dec_c.load & full;
  assign ready_c      = !bus.flush && !hit && !sb_block && (!vld_p1 || bus.out_ready);
  assign accept       = bus.in_valid & ready_c;
  assign bus.in_ready = ready_c;

  load_scoreboard #(
    .SB_DEPTH (SB_DEPTH),
    .LOAD_LAT (LOAD_LAT)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .alloc    (accept & dec_c.load),
    .alloc_rd (dec_c.rd),
    .q_addr   (q_addr),
    .q_en     (q_en),
    .hit      (hit),
    .full     (full)
  );

  // ---- stage p1: ID/EX register and illegal-opcode counter ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_p1      <= '0;
      vld_p1      <= 1'b0;
      illegal_cnt <= '0;
    end else begin
      if (accept) begin
        dec_p1 <= dec_c;
        vld_p1 <= 1'b1;
      end else if (bus.flush || (vld_p1 && bus.out_ready)) begin
        vld_p1 <= 1'b0;
      end
      if (accept && dec_c.illegal) illegal_cnt <= sat_inc(illegal_cnt);
    end
  end

  assign bus.out_valid    = vld_p1;
  assign bus.out_ra       = dec_p1.ra;
  assign bus.out_rb       = dec_p1.rb;
  assign bus.out_rd       = dec_p1.rd;
  assign bus.out_ww       = dec_p1.ww;
  assign bus.out_func     = dec_p1.func;
  assign bus.out_br       = dec_p1.br;
  assign bus.out_imm      = dec_p1.imm;
  assign bus.out_wr_en    = dec_p1.wr_en;
  assign bus.out_mem_en   = dec_p1.mem_en;
  assign bus.out_store_en = dec_p1.store_en;
  assign bus.out_load     = dec_p1.load;
  assign bus.out_illegal  = dec_p1.illegal;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// Directed bench for decode_stage_pipe with default parameters
// (LOAD_LAT=2, SB_DEPTH=2, CNT_W=8).
module tb_decode_stage_pipe;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] illegal_cnt;
  int         n_chk  = 0;
  int         n_fail = 0;

  localparam logic [31:0] NOP_W = 32'hF000_0000;
  localparam logic [31:0] ILL_W = 32'hFC00_0000;

  decode_stage_pipe_if bus();

  decode_stage_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [31:0] w);
    bus.in_valid = v;
    bus.in_instr = w;
    #1;
  endtask

  function automatic logic [31:0] r_ins(input logic [4:0] rd, ra, rb, ww, input logic [5:0] fn);
    return {6'b101010, rd, ra, rb, ww, fn};
  endfunction

  function automatic logic [31:0] m_ins(input logic [5:0] op, input logic [4:0] a, input logic [15:0] imm);
    return {op, a, 5'd0, imm};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_instr  = NOP_W;
    bus.flush     = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_cnt",       32'(illegal_cnt),   0);
    chk("rst_rd",        32'(bus.out_rd),    0);
    chk("rst_in_ready",  32'(bus.in_ready),  1);
    rst_n = 1'b1;
    step();

    // R-type rd=1 ra=1 rb=2
    drive(1'b1, r_ins(5'd1, 5'd1, 5'd2, 5'd0, 6'd0));
    chk("r_in_ready", 32'(bus.in_ready), 1);
    step();
    chk("r_valid", 32'(bus.out_valid), 1);
    chk("r_wr_en", 32'(bus.out_wr_en), 1);
    chk("r_br",    32'(bus.out_br),    0);
    chk("r_rd",    32'(bus.out_rd),    1);
    chk("r_ra",    32'(bus.out_ra),    1);
    chk("r_rb",    32'(bus.out_rb),    2);
    chk("r_mem",   32'(bus.out_mem_en), 0);

    drive(1'b1, r_ins(5'd4, 5'd5, 5'd6, 5'd3, 6'd5));
    step();
    chk("r2_ww",   32'(bus.out_ww),   3);
    chk("r2_func", 32'(bus.out_func), 5);
    chk("r2_rb",   32'(bus.out_rb),   6);

    drive(1'b1, m_ins(6'b100010, 5'd4, 16'h1234));
    step();
    chk("vbnz_br",  32'(bus.out_br),    32'h2);
    chk("vbnz_ra",  32'(bus.out_ra),    4);
    chk("vbnz_imm", 32'(bus.out_imm),   32'h1234);
    chk("vbnz_wr",  32'(bus.out_wr_en), 0);
    chk("vbnz_rd",  32'(bus.out_rd),    0);

    drive(1'b1, m_ins(6'b100011, 5'd9, 16'hFFFE));
    step();
    chk("vbenz_br",  32'(bus.out_br),  32'h3);
    chk("vbenz_imm", 32'(bus.out_imm), 32'hFFFE);

    drive(1'b1, m_ins(6'b100001, 5'd7, 16'h0040));
    step();
    chk("sd_store", 32'(bus.out_store_en), 1);
    chk("sd_mem",   32'(bus.out_mem_en),   1);
    chk("sd_rd",    32'(bus.out_rd),       7);
    chk("sd_wr",    32'(bus.out_wr_en),    0);
    chk("sd_load",  32'(bus.out_load),     0);

    drive(1'b1, NOP_W);
    step();
    chk("nop_valid", 32'(bus.out_valid),   1);
    chk("nop_wr",    32'(bus.out_wr_en),   0);
    chk("nop_mem",   32'(bus.out_mem_en),  0);
    chk("nop_imm",   32'(bus.out_imm),     0);
    chk("nop_ill",   32'(bus.out_illegal), 0);

    // Load-use interlock: LD r3 then R-type reading r3
    drive(1'b1, m_ins(6'b100000, 5'd3, 16'h0100));
    chk("lu_ld_ready", 32'(bus.in_ready), 1);
    step();
    chk("lu_ld_load", 32'(bus.out_load),  1);
    chk("lu_ld_rd",   32'(bus.out_rd),    3);
    chk("lu_ld_imm",  32'(bus.out_imm),   32'h100);
    chk("lu_ld_wr",   32'(bus.out_wr_en), 1);
    drive(1'b1, r_ins(5'd5, 5'd3, 5'd4, 5'd0, 6'd1));
    chk("lu_stall1", 32'(bus.in_ready), 0);
    step();
    #1;
    chk("lu_stall2", 32'(bus.in_ready), 0);
    step();
    #1;
    chk("lu_go", 32'(bus.in_ready), 1);
    step();
    chk("lu_issue_valid", 32'(bus.out_valid), 1);
    chk("lu_issue_ra",    32'(bus.out_ra),    3);

    // Three back-to-back loads into a two-entry scoreboard
    drive(1'b1, m_ins(6'b100000, 5'd10, 16'h0010));
    chk("ld3_a_ready", 32'(bus.in_ready), 1);
    step();
    drive(1'b1, m_ins(6'b100000, 5'd11, 16'h0011));
    chk("ld3_b_ready", 32'(bus.in_ready), 1);
    step();
    drive(1'b1, m_ins(6'b100000, 5'd12, 16'h0012));
    chk("ld3_c_full", 32'(bus.in_ready), 0);
    step();
    #1;
    chk("ld3_gap_valid", 32'(bus.out_valid), 0);
    chk("ld3_c_ready",   32'(bus.in_ready),  1);
    step();
    chk("ld3_c_rd",   32'(bus.out_rd),   12);
    chk("ld3_c_load", 32'(bus.out_load), 1);
    drive(1'b0, NOP_W);
    repeat (3) step();

    // Back-pressure: hold the register for four cycles
    drive(1'b1, r_ins(5'd6, 5'd7, 5'd8, 5'd9, 6'h11));
    step();
    bus.out_ready = 1'b0;
    drive(1'b1, m_ins(6'b100001, 5'd20, 16'h0055));
    for (int k = 0; k < 4; k++) begin
      chk("bp_in_ready", 32'(bus.in_ready),  0);
      chk("bp_valid",    32'(bus.out_valid), 1);
      chk("bp_rd",       32'(bus.out_rd),    6);
      chk("bp_func",     32'(bus.out_func),  32'h11);
      step();
      #1;
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(bus.in_ready), 1);
    step();
    chk("bp_next_store", 32'(bus.out_store_en), 1);
    chk("bp_next_rd",    32'(bus.out_rd),       20);

    // Flush on a load: squashed, no scoreboard entry
    bus.flush = 1'b1;
    drive(1'b1, m_ins(6'b100000, 5'd9, 16'h0099));
    chk("fl_in_ready", 32'(bus.in_ready), 0);
    step();
    chk("fl_valid", 32'(bus.out_valid), 0);
    bus.flush = 1'b0;
    drive(1'b1, r_ins(5'd1, 5'd9, 5'd9, 5'd0, 6'd0));
    chk("fl_no_alloc", 32'(bus.in_ready), 1);
    step();
    chk("fl_next_ra", 32'(bus.out_ra), 9);

    // Flush on an illegal op: no count
    bus.flush = 1'b1;
    drive(1'b1, ILL_W);
    step();
    bus.flush = 1'b0;
    drive(1'b0, NOP_W);
    chk("fl_ill_cnt", 32'(illegal_cnt), 0);
    step();

    // Illegal opcode 300 times: counter saturates at 255
    drive(1'b1, ILL_W);
    for (int k = 1; k <= 300; k++) begin
      step();
      chk("ill_flag", 32'(bus.out_illegal), 1);
      chk("ill_cnt",  32'(illegal_cnt), (k < 255) ? k : 255);
    end
    chk("ill_wr", 32'(bus.out_wr_en),  0);
    chk("ill_mem", 32'(bus.out_mem_en), 0);
    drive(1'b0, NOP_W);
    step();

    // Asynchronous reset mid-operation
    drive(1'b1, m_ins(6'b100000, 5'd13, 16'h0013));
    step();
    chk("ar_pre_valid", 32'(bus.out_valid), 1);
    drive(1'b0, NOP_W);
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 32'(bus.out_valid), 0);
    chk("ar_cnt",   32'(illegal_cnt),   0);
    chk("ar_rd",    32'(bus.out_rd),    0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, r_ins(5'd2, 5'd13, 5'd13, 5'd0, 6'd0));
    chk("ar_sb_clear", 32'(bus.in_ready), 1);
    step();
    chk("ar_issue_ra", 32'(bus.out_ra), 13);
    drive(1'b0, NOP_W);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
